alu_pipe_flags: RTL and testbench
=================================

// Module: alu_pipe_flags
// PURPOSE
//  Registered, handshaked ALU with an architectural NZCV status register, generalised in WIDTH.
//  Sits in the EXE stage between the operand/decode latch and the MEM latch.
//  ADC/SBC take carry-in from the internal C flag; flags change only when setStatus is high.
// PARAMETERS
//  WIDTH   32   operand/result width (>=8)
//  CMD_W   4    exeCommand width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  in_valid     in   1      operation offered
//  in_ready     out  1      unit can accept an operation
//  inputA       in   WIDTH  operand A (Rn)
//  inputB       in   WIDTH  operand B (shifter operand)
//  exeCommand   in   CMD_W  opcode
//  setStatus    in   1      commit flags for this op (S bit)
//  out_valid    out  1      result held on result/statusOut
//  out_ready    in   1      consumer takes the result
//  result       out  WIDTH  registered result
//  statusOut    out  4      {N,Z,C,V}: status register after this op
//  illegalOp    out  1      with out_valid: opcode not decoded
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, result=0, statusOut=0, illegalOp=0, FSM=IDLE; takes effect immediately.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Single-cycle ops: result, flags and out_valid=1 are registered on the accept edge (latency 1).
//  out_valid holds with stable result/statusOut/illegalOp until out_ready; accept+drain in the same cycle gives back-to-back throughput.
//  Opcodes: 0001 MOV=B; 1001 MVN=~B; 0010 ADD=A+B; 0011 ADC=A+B+C;
//   0100 SUB=A+~B+1; 0101 SBC=A+~B+C; 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL (macro only).
//  Arithmetic: computed at WIDTH+1 bits; C=bit WIDTH (for SUB/SBC C=1 means no borrow).
//  V(add)=(A[W-1]==B[W-1])&(R[W-1]!=A[W-1]); V(sub)=(A[W-1]!=B[W-1])&(R[W-1]!=A[W-1]).
//  Logic/MOV/MVN/MUL: N,Z updated; C,V retain their old values.
//  setStatus=0: status register unchanged; statusOut still shows it.
//  Carry-in is read from the status register at accept, so ADDS then ADC back-to-back sees the new C.
//  Undecoded opcode: result=0, illegalOp=1, status unchanged regardless of setStatus.
//  FSM: IDLE -> (accept MUL) MUL_BUSY -> (count==WIDTH-1) IDLE with out_valid=1; other ops stay in IDLE.
//  Reset during MUL_BUSY aborts the op: no output is produced and flags clear to 0.
// CONFIGURATION
//  ALU_MUL_EN defined: opcode 1010 = low WIDTH bits of A*B via iterative shift-add, one bit per cycle.
//   MUL latency WIDTH+1 cycles from accept to out_valid; in_ready=0 while busy.
//  ALU_MUL_EN undefined: 1010 is undecoded (illegalOp path), MUL_BUSY is never entered, and no multiplier logic is built.
// STRUCTURE
//  Package alu_pkg: opcode localparams (ALU_MOV..ALU_MUL), flag index constants (FLG_N=3..FLG_V=0), FSM state encoding.
//  Sub-module alu_iter_mul: start/done handshake, WIDTH-bit shift-add; instanced only under ALU_MUL_EN.
//  Top: combinational datapath, flag logic, output register, FSM.
// TESTING
//  ADDS A=0x7FFFFFFF, B=1 -> result 0x80000000, NZCV=1001 after 1 cycle.
//  SUBS A=5, B=5 -> result 0, NZCV=0110; then ADC A=1, B=1 -> result 3.
//  ADDS A=0xFFFFFFFF, B=1 with setStatus=0 -> result 0 and flags unchanged; with setStatus=1 -> NZCV=0110.
//  out_ready held low 3 cycles, in_valid high -> in_ready=0, result stable, nothing lost; stream of 8 ops with out_ready=1 -> 8 results on consecutive cycles.
//  exeCommand=1111, setStatus=1 -> illegalOp=1, result=0, flags unchanged.
//  ALU_MUL_EN: MULS 7*6 -> 42 after 33 cycles, in_ready=0 meanwhile; rst_n low mid-MUL -> out_valid=0, NZCV=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, NZCV flag indices and FSM encoding shared by the ALU slice
package alu_pkg;
  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1010;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_e;
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: iterative shift-add multiplier, low WIDTH bits of a_i*b_i
// Ports: clk, rst_n (async, active low); start_i loads a_i/b_i; done_o pulses
//   one cycle with product_o valid, WIDTH cycles after start_i.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_iter_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic busy_q, done_q;
  assign done_o = done_q;
  assign product_o = acc_q;
  // one multiplier bit per cycle; done is registered after the last bit lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= '0;
      mcand_q <= a_i;
      mplier_q <= b_i;
      cnt_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= busy_q && cnt_q == CNT_W'(WIDTH - 1);
      if (busy_q) begin
        acc_q <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q <= cnt_q + CNT_W'(1);
        busy_q <= cnt_q != CNT_W'(WIDTH - 1);
      end
    end
endmodule
`endif

// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: registered, handshaked EXE-stage ALU with an NZCV status register
// Ports: clk, rst_n (async, active low)
//   in_valid/in_ready  : operation inputA, inputB, exeCommand, setStatus
//   out_valid/out_ready: result, statusOut {N,Z,C,V}, illegalOp
// Build option ALU_MUL_EN: opcode 1010 multiplies via alu_iter_mul (WIDTH+1 cycles);
//   without it 1010 is undecoded.
module alu_pipe_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [CMD_W-1:0] exeCommand,
  input  logic             setStatus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic             illegalOp
);
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, illegal_q, illegal_d, set_q, set_d;
  logic [WIDTH-1:0] result_q, result_d, b_op, res_c, mul_prod;
  logic [3:0] status_q, status_d, nzcv_c;
  logic [WIDTH:0] sum;
  logic sub_op, cin, ovf, arith, legal, is_mul, accept, mul_done;
  assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign statusOut = status_q;
  assign illegalOp = illegal_q;
  // subtraction is A + ~B + carry, so C=1 means no borrow and one adder serves all four
  always_comb begin
    sub_op = exeCommand == CMD_W'(ALU_SUB) || exeCommand == CMD_W'(ALU_SBC);
    cin = (exeCommand == CMD_W'(ALU_ADC) || exeCommand == CMD_W'(ALU_SBC)) ? status_q[FLG_C] : sub_op;
    b_op = sub_op ? ~inputB : inputB;
    sum = {1'b0, inputA} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    ovf = (inputA[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != inputA[WIDTH-1]);
    res_c = '0;
    arith = 1'b0;
    legal = 1'b1;
    is_mul = 1'b0;
    case (exeCommand)
      CMD_W'(ALU_MOV): res_c = inputB;
      CMD_W'(ALU_MVN): res_c = ~inputB;
      CMD_W'(ALU_ADD), CMD_W'(ALU_ADC), CMD_W'(ALU_SUB), CMD_W'(ALU_SBC): begin
        res_c = sum[WIDTH-1:0];
        arith = 1'b1;
      end
      CMD_W'(ALU_AND): res_c = inputA & inputB;
      CMD_W'(ALU_ORR): res_c = inputA | inputB;
      CMD_W'(ALU_EOR): res_c = inputA ^ inputB;
`ifdef ALU_MUL_EN
      CMD_W'(ALU_MUL): is_mul = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    nzcv_c = {res_c[WIDTH-1], res_c == '0, arith ? {sum[WIDTH], ovf} : status_q[FLG_C:FLG_V]};
  end
`ifdef ALU_MUL_EN
  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept & is_mul),
    .a_i      (inputA),
    .b_i      (inputB),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`else
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif
  // a held result drops only when drained; MUL defers result and flags to completion
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q & ~out_ready;
    result_d = result_q;
    status_d = status_q;
    illegal_d = illegal_q;
    set_d = set_q;
    if (state_q == ST_IDLE && accept) begin
      if (is_mul) begin
        state_d = ST_MUL_BUSY;
        set_d = setStatus;
      end else begin
        out_valid_d = 1'b1;
        result_d = res_c;
        illegal_d = ~legal;
        status_d = (legal & setStatus) ? nzcv_c : status_q;
      end
    end else if (state_q == ST_MUL_BUSY && mul_done) begin
      state_d = ST_IDLE;
      out_valid_d = 1'b1;
      result_d = mul_prod;
      illegal_d = 1'b0;
      status_d = set_q ? {mul_prod[WIDTH-1], mul_prod == '0, status_q[FLG_C:FLG_V]} : status_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      illegal_q <= 1'b0;
      set_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      status_q <= status_d;
      illegal_q <= illegal_d;
      set_q <= set_d;
    end
endmodule

// File: tb/tb_alu_pipe_flags.sv
// tb_alu_pipe_flags: directed and randomized checks of alu_pipe_flags against a behavioural model
`timescale 1ns/1ps
module tb_alu_pipe_flags;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, setStatus = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, illegalOp;
  logic [31:0] inputA = '0, inputB = '0, result;
  logic [3:0] exeCommand = '0, statusOut;
  int n_cmp = 0, n_err = 0, cyc = 0, drains = 0, or_mode = 1;
  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic        ill;
    int          rdy;
  } exp_t;
  exp_t q[$];
  logic [3:0] mf = '0;
  always #5 clk = ~clk;
  alu_pipe_flags dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .exeCommand(exeCommand), .setStatus(setStatus),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .statusOut(statusOut), .illegalOp(illegalOp)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference: plain integer arithmetic, signed range test for V, a>=b test for no-borrow
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic s, inout logic [3:0] f, output logic [31:0] r,
                                output logic ill, output logic mul);
    longint full, sfull, k;
    logic ar, c;
    full = 0; sfull = 0; ar = 0; c = 0; r = '0; ill = 0; mul = 0;
    case (op)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        k = (op == 4'd3) ? longint'(f[1]) : 0;
        full = longint'(a) + longint'(b) + k;
        sfull = longint'($signed(a)) + longint'($signed(b)) + k;
        c = full > 64'sd4294967295;
        ar = 1;
      end
      4'd4, 4'd5: begin
        k = (op == 4'd5) ? longint'(!f[1]) : 0;
        full = longint'(a) - longint'(b) - k;
        sfull = longint'($signed(a)) - longint'($signed(b)) - k;
        c = longint'(a) >= longint'(b) + k;
        ar = 1;
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd10: begin
`ifdef ALU_MUL_EN
        r = a * b;
        mul = 1;
`else
        ill = 1;
`endif
      end
      default: ill = 1;
    endcase
    if (ar) r = full[31:0];
    if (s && !ill) begin
      f[3] = r[31];
      f[2] = (r == 0);
      if (ar) begin
        f[1] = c;
        f[0] = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
      end
    end
  endfunction
  // scoreboard: every falling edge checks handshake and any presented result, then logs accepts
  always @(negedge clk) begin
    logic ev, ill, mul;
    logic [31:0] r;
    cyc++;
    if (!rst_n) begin
      q.delete();
      mf = '0;
    end else begin
      ev = (q.size() > 0) ? (cyc >= q[0].rdy) : 1'b0;
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, q.size() == 0 || (ev && out_ready));
      if (ev && out_valid) begin
        check("sb_result", result, q[0].r);
        check("sb_nzcv", statusOut, q[0].f);
        check("sb_illegal", illegalOp, q[0].ill);
        if (out_ready) begin
          void'(q.pop_front());
          drains++;
        end
      end
      if (in_valid && in_ready) begin
        model(inputA, inputB, exeCommand, setStatus, mf, r, ill, mul);
        q.push_back(exp_t'{r, mf, ill, cyc + (mul ? 33 : 1)});
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1 out_ready = (or_mode == 2) ? ($urandom_range(0, 99) < 65) : (or_mode == 1);
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic s, output int n);
    logic acc;
    inputA = a; inputB = b; exeCommand = op; setStatus = s; in_valid = 1'b1; n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2 n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask
  task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic s, input logic [31:0] er,
                     input logic [3:0] ef, input logic ei, output int lat);
    int w;
    send(a, b, op, s, w);
    wait_valid(lat);
    check({tag, "_res"}, result, er);
    check({tag, "_nzcv"}, statusOut, ef);
    check({tag, "_ill"}, illegalOp, ei);
    @(posedge clk);
    #2;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, t, lat, d0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_nzcv", statusOut, 0);
    check("rst_illegal", illegalOp, 0);
    @(posedge clk);
    #2;
    op1("adds_ovf", 32'h7FFF_FFFF, 32'h1, 4'd2, 1, 32'h8000_0000, 4'b1001, 0, lat);
    check("single_latency", lat, 1);
    op1("add_nos", 32'hFFFF_FFFF, 32'h1, 4'd2, 0, 32'h0, 4'b1001, 0, lat);
    op1("adds_carry", 32'hFFFF_FFFF, 32'h1, 4'd2, 1, 32'h0, 4'b0110, 0, lat);
    op1("subs_eq", 32'd5, 32'd5, 4'd4, 1, 32'h0, 4'b0110, 0, lat);
    op1("adc_cin", 32'd1, 32'd1, 4'd3, 0, 32'd3, 4'b0110, 0, lat);
    op1("subs_borrow", 32'd3, 32'd5, 4'd4, 1, 32'hFFFF_FFFE, 4'b1000, 0, lat);
    op1("sbcs", 32'd10, 32'd3, 4'd5, 1, 32'd6, 4'b0010, 0, lat);
    op1("movs_keepcv", 32'h0, 32'h8000_0000, 4'd1, 1, 32'h8000_0000, 4'b1010, 0, lat);
    op1("illegal", 32'd1, 32'd2, 4'd15, 1, 32'h0, 4'b1010, 1, lat);
`ifdef ALU_MUL_EN
    op1("muls", 32'd7, 32'd6, 4'd10, 1, 32'd42, 4'b0010, 0, lat);
    check("mul_latency", lat, 33);
`else
    op1("mul_off", 32'd7, 32'd6, 4'd10, 1, 32'h0, 4'b1010, 1, lat);
`endif
    or_mode = 0;
    send(32'd100, 32'd23, 4'd2, 1, w);
    inputA = 32'd9; inputB = 32'd4; exeCommand = 4'd4; setStatus = 1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'd123);
    end
    or_mode = 1;
    @(posedge clk);
    #2;
    send(32'd9, 32'd4, 4'd4, 1, w);
    wait_valid(lat);
    check("bp_second", result, 32'd5);
    @(posedge clk);
    #2;
    d0 = drains;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      send(pick(), pick(), 4'd2 + 4'(i % 7), 1'($urandom_range(0, 1)), w);
      t += w;
    end
    check("stream_cycles", t, 8);
    repeat (2) @(negedge clk);
    check("stream_drains", drains - d0, 8);
    @(posedge clk);
    #2 or_mode = 0;
    op1("pre_rst", 32'h7FFF_FFFF, 32'h1, 4'd2, 1, 32'h8000_0000, 4'b1001, 0, lat);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_nzcv", statusOut, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    or_mode = 1;
`ifdef ALU_MUL_EN
    op1("pre_mul", 32'h7FFF_FFFF, 32'h1, 4'd2, 1, 32'h8000_0000, 4'b1001, 0, lat);
    send(32'd7, 32'd6, 4'd10, 1, w);
    repeat (10) @(negedge clk);
    check("mul_busy_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mul_abort_valid", out_valid, 0);
    check("mul_abort_nzcv", statusOut, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2;
`endif
    or_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send(pick(), pick(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
    end
    or_mode = 1;
    repeat (50) @(negedge clk);
    check("drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
